// File: rtl/regfile_pkg.sv
// Shared defaults and FSM state type for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: x0 forced to zero, optional same-cycle write bypass, busy lookup.
// Bypass muxing is compiled in only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              i_ready,
  input  logic [AW-1:0]     i_raddr,
  input  logic [XLEN-1:0]   i_rdata_q,
  input  logic [NREG-1:0]   i_busy_q,
`ifdef REGFILE_BYPASS_EN
  input  logic [1:0]        i_wen,
  input  logic [2*AW-1:0]   i_waddr,
  input  logic [2*XLEN-1:0] i_wdata,
  input  logic              i_sb_set,
  input  logic [AW-1:0]     i_sb_addr,
`endif
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_rbusy
);

`ifdef REGFILE_BYPASS_EN
  logic w_sb_hit;
  logic w_hit0;
  logic w_hit1;

  assign w_sb_hit = i_sb_set && (i_sb_addr == i_raddr);
  assign w_hit0   = i_wen[0] && (i_waddr[0 +: AW] == i_raddr);
  assign w_hit1   = i_wen[1] && (i_waddr[AW +: AW] == i_raddr);
`endif

  // Write enables arriving here are already qualified (READY, non-zero address).
  always_comb begin
    o_rdata = '0;
    o_rbusy = 1'b0;
    if (i_ready && (i_raddr != '0)) begin
      o_rdata = i_rdata_q;
      o_rbusy = i_busy_q[i_raddr];
`ifdef REGFILE_BYPASS_EN
      if (w_hit1) begin
        o_rdata = i_wdata[XLEN +: XLEN];
        o_rbusy = w_sb_hit;
      end else if (w_hit0) begin
        o_rdata = i_wdata[0 +: XLEN];
        o_rbusy = w_sb_hit;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard and a post-reset zeroing sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic [1:0]          wen_i,
  input  logic [2*AW-1:0]     waddr_i,
  input  logic [2*XLEN-1:0]   wdata_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_set_addr_i,
  input  logic                flush_i,
  output logic                ready_o
);

  state_e          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_run;
  logic [1:0]      w_we;
  logic            w_sb_set;
  logic            w_flush;

  assign ready_o  = r_ready;
  assign w_run    = (r_state == READY);
  assign w_we[0]  = wen_i[0] && w_run && (waddr_i[0 +: AW] != '0);
  assign w_we[1]  = wen_i[1] && w_run && (waddr_i[AW +: AW] != '0);
  assign w_sb_set = sb_set_i && w_run && (sb_set_addr_i != '0);
  assign w_flush  = flush_i && w_run;

  // Sweep FSM: zero registers 1..NREG-1, then stay READY until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= CLEAR;
      r_cnt   <= AW'(1);
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == AW'(NREG - 1)) begin
            r_state <= READY;
            r_ready <= 1'b1;
          end
        end
        READY: begin
          r_state <= READY;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= CLEAR;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep provides the zeroes. Port 1 is written last so it wins.
  always_ff @(posedge clk_i) begin
    if (r_state == CLEAR) begin
      r_regs[r_cnt] <= '0;
    end else begin
      if (w_we[0]) r_regs[waddr_i[0 +: AW]] <= wdata_i[0 +: XLEN];
      if (w_we[1]) r_regs[waddr_i[AW +: AW]] <= wdata_i[XLEN +: XLEN];
    end
  end

  // Flush beats everything; otherwise writes clear and a set applied afterwards wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_we[0]) w_busy_nxt[waddr_i[0 +: AW]] = 1'b0;
      if (w_we[1]) w_busy_nxt[waddr_i[AW +: AW]] = 1'b0;
      if (w_sb_set) w_busy_nxt[sb_set_addr_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_raddr;
    assign w_raddr = raddr_i[g*AW +: AW];

    regfile_rdport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rdport (
      .i_ready   (w_run),
      .i_raddr   (w_raddr),
      .i_rdata_q (r_regs[w_raddr]),
      .i_busy_q  (r_busy),
`ifdef REGFILE_BYPASS_EN
      .i_wen     (w_we),
      .i_waddr   (waddr_i),
      .i_wdata   (wdata_i),
      .i_sb_set  (w_sb_set),
      .i_sb_addr (sb_set_addr_i),
`endif
      .o_rdata   (rdata_o[g*XLEN +: XLEN]),
      .o_rbusy   (rbusy_o[g])
    );
  end

endmodule
